// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master bus arbiter: state encodings,
// master count and watchdog defaults.
package bus_arb_pkg;

    // Non-idle encodings double as the one-hot grant vector {m1,m0}.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_t;

    localparam int NUM_MASTERS     = 2;
    localparam int DEFAULT_TIMEOUT = 255;
    localparam int WDOG_WIDTH      = 32;

endpackage

// File: rtl/bus_watchdog.sv
// Slave-response watchdog: counts stalled cycles of the current grant and
// flags when the count reaches a non-zero limit.
module bus_watchdog
    import bus_arb_pkg::*;
#(
    parameter int WIDTH = WDOG_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             run,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Saturate at all-ones so a disabled watchdog never wraps back into range.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != '1)) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign expired = (limit != '0) && (count == limit);

endmodule

// File: rtl/bus_arbiter2.sv
// Round-robin arbiter sharing one slave bus between a CPU (m0) and a
// secondary master (m1), with a slave-response watchdog.
module bus_arbiter2
    import bus_arb_pkg::*;
#(
    parameter int          TIMEOUT       = DEFAULT_TIMEOUT,
    parameter logic [31:0] TIMEOUT_RDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic        m1_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m0_wstrb,
    input  logic [3:0]  m1_wstrb,
    output logic        m0_ready,
    output logic        m1_ready,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        err_timeout
);

    localparam logic [WDOG_WIDTH-1:0] WDOG_LIMIT = WDOG_WIDTH'(TIMEOUT);

    arb_state_t             state;
    logic                   last_grant;
    logic [NUM_MASTERS-1:0] req;
    logic                   sel_valid;
    logic                   wd_expired;
    logic                   timeout_hit;
    logic                   done;
    logic [31:0]            resp_rdata;

    assign req       = {m1_valid, m0_valid};
    assign sel_valid = (state == GNT0) ? m0_valid :
                       (state == GNT1) ? m1_valid : 1'b0;

    // A real s_ready in the expiry cycle wins: that is a normal completion.
    assign timeout_hit = sel_valid && wd_expired && !s_ready;
    assign done        = sel_valid && (s_ready || timeout_hit);
    assign resp_rdata  = timeout_hit ? TIMEOUT_RDATA : s_rdata;
    assign err_timeout = timeout_hit;
    assign grant       = state;

    bus_watchdog #(
        .WIDTH (WDOG_WIDTH)
    ) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (state == IDLE),
        .run     ((state != IDLE) && !s_ready),
        .limit   (WDOG_LIMIT),
        .expired (wd_expired)
    );

    // A dropped valid ends the grant like a completion, but without ready.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req == 2'b11) begin
                        state <= last_grant ? GNT0 : GNT1;
                    end else if (req[0]) begin
                        state <= GNT0;
                    end else if (req[1]) begin
                        state <= GNT1;
                    end
                end
                GNT0: begin
                    if (!m0_valid || done) begin
                        state      <= IDLE;
                        last_grant <= 1'b0;
                    end
                end
                GNT1: begin
                    if (!m1_valid || done) begin
                        state      <= IDLE;
                        last_grant <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        case (state)
            GNT0: begin
                s_valid  = m0_valid && !timeout_hit;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = done;
                m0_rdata = resp_rdata;
            end
            GNT1: begin
                s_valid  = m1_valid && !timeout_hit;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = done;
                m1_rdata = resp_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Self-checking bench for bus_arbiter2: directed vector table, corner-case
// sequences and randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_bus_arbiter2;

    localparam int          TO  = 8;
    localparam logic [31:0] TRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        err_timeout;

    always #5 clk = ~clk;

    bus_arbiter2 #(
        .TIMEOUT       (TO),
        .TIMEOUT_RDATA (TRD)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .m0_valid    (m0_valid),
        .m1_valid    (m1_valid),
        .m0_addr     (m0_addr),
        .m1_addr     (m1_addr),
        .m0_wdata    (m0_wdata),
        .m1_wdata    (m1_wdata),
        .m0_wstrb    (m0_wstrb),
        .m1_wstrb    (m1_wstrb),
        .m0_ready    (m0_ready),
        .m1_ready    (m1_ready),
        .m0_rdata    (m0_rdata),
        .m1_rdata    (m1_rdata),
        .s_valid     (s_valid),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .grant       (grant),
        .err_timeout (err_timeout)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: who owns the bus, who was served last, and
    // how many stalled cycles the current owner has waited.
    int owner      = -1;
    int last_owner = 1;
    int waited     = 0;
    logic exp_r0, exp_r1;

    typedef struct {
        logic        v0, v1, sr;
        logic [31:0] srd;
        logic [1:0]  eg;
        logic        er0, er1, eerr;
        logic [31:0] erd0, erd1;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic ownerValid();
        return (owner == 0) ? m0_valid : (owner == 1) ? m1_valid : 1'b0;
    endfunction

    task automatic modelReset();
        owner      = -1;
        last_owner = 1;
        waited     = 0;
    endtask

    task automatic modelAdvance();
        logic ov, to, fin;
        ov  = ownerValid();
        to  = ov && (waited == TO) && !s_ready;
        fin = ov && (s_ready || to);
        if (owner < 0) begin
            if (m0_valid && m1_valid) owner = (last_owner == 0) ? 1 : 0;
            else if (m0_valid)        owner = 0;
            else if (m1_valid)        owner = 1;
            waited = 0;
        end else if (!ov || fin) begin
            last_owner = owner;
            owner      = -1;
        end else begin
            waited++;
        end
    endtask

    task automatic checkModel(input int cyc);
        logic ov, to, fin, esv;
        logic [1:0]  eg;
        logic [31:0] ea, ew, erd;
        logic [3:0]  es;
        ov  = ownerValid();
        to  = ov && (waited == TO) && !s_ready;
        fin = ov && (s_ready || to);
        erd = to ? TRD : s_rdata;
        eg  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        esv = ov && !to;
        ea  = (owner == 0) ? m0_addr  : (owner == 1) ? m1_addr  : 32'h0;
        ew  = (owner == 0) ? m0_wdata : (owner == 1) ? m1_wdata : 32'h0;
        es  = (owner == 0) ? m0_wstrb : (owner == 1) ? m1_wstrb : 4'h0;
        exp_r0 = (owner == 0) && fin;
        exp_r1 = (owner == 1) && fin;
        checkOutput($sformatf("grant@%0d", cyc),    32'(grant),       32'(eg));
        checkOutput($sformatf("s_valid@%0d", cyc),  32'(s_valid),     32'(esv));
        checkOutput($sformatf("s_addr@%0d", cyc),   s_addr,           ea);
        checkOutput($sformatf("s_wdata@%0d", cyc),  s_wdata,          ew);
        checkOutput($sformatf("s_wstrb@%0d", cyc),  32'(s_wstrb),     32'(es));
        checkOutput($sformatf("m0_ready@%0d", cyc), 32'(m0_ready),    32'(exp_r0));
        checkOutput($sformatf("m1_ready@%0d", cyc), 32'(m1_ready),    32'(exp_r1));
        checkOutput($sformatf("m0_rdata@%0d", cyc), m0_rdata,         (owner == 0) ? erd : 32'h0);
        checkOutput($sformatf("m1_rdata@%0d", cyc), m1_rdata,         (owner == 1) ? erd : 32'h0);
        checkOutput($sformatf("err@%0d", cyc),      32'(err_timeout), 32'(to));
    endtask

    // Advance the model on the edge using the inputs the DUT saw, then drive
    // the next cycle's inputs and return at the sampling (falling) edge.
    task automatic applyStimulus(input logic v0, input logic v1, input logic sr,
                                 input logic [31:0] srd, input logic rnd);
        @(posedge clk);
        modelAdvance();
        #1;
        m0_valid = v0;
        m1_valid = v1;
        s_ready  = sr;
        s_rdata  = srd;
        if (rnd) begin
            m0_addr  = $urandom();
            m1_addr  = $urandom();
            m0_wdata = $urandom();
            m1_wdata = $urandom();
            m0_wstrb = 4'($urandom_range(0, 15));
            m1_wstrb = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        resetn   = 1'b0;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        s_ready  = 1'b0;
        s_rdata  = '0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int n;
        int found;
        logic v0, v1;

        m0_addr  = 32'h0000_0010;
        m1_addr  = 32'h9000_0000;
        m0_wdata = 32'h0;
        m1_wdata = 32'h0;
        m0_wstrb = 4'h0;
        m1_wstrb = 4'h0;

        //            v0 v1 sr  srd           grant  r0 r1 err rd0           rd1
        vecs[0]  = '{1, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0};
        vecs[1]  = '{1, 0, 1, 32'h1234_5678, 2'b01, 1, 0, 0, 32'h1234_5678, 32'h0};
        vecs[2]  = '{0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0};
        vecs[3]  = '{0, 1, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0};
        vecs[4]  = '{0, 1, 0, 32'h0,        2'b10, 0, 0, 0, 32'h0,        32'h0};
        vecs[5]  = '{0, 1, 1, 32'hAAAA_5555, 2'b10, 0, 1, 0, 32'h0,        32'hAAAA_5555};
        vecs[6]  = '{0, 0, 1, 32'hBBBB_0000, 2'b00, 0, 0, 0, 32'h0,        32'h0};
        vecs[7]  = '{1, 1, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0};
        vecs[8]  = '{1, 1, 1, 32'h1111_1111, 2'b01, 1, 0, 0, 32'h1111_1111, 32'h0};
        vecs[9]  = '{0, 1, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0};
        vecs[10] = '{0, 1, 1, 32'h2222_2222, 2'b10, 0, 1, 0, 32'h0,        32'h2222_2222};
        vecs[11] = '{0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0};

        // Reset values while resetn is low.
        resetn = 1'b0;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        s_ready  = 1'b1;
        s_rdata  = 32'h5555_AAAA;
        #3;
        checkOutput("reset grant",   32'(grant),       32'h0);
        checkOutput("reset s_valid", 32'(s_valid),     32'h0);
        checkOutput("reset ready",   32'({m1_ready, m0_ready}), 32'h0);
        checkOutput("reset err",     32'(err_timeout), 32'h0);
        doReset();

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].v0, vecs[i].v1, vecs[i].sr, vecs[i].srd, 1'b0);
            checkOutput($sformatf("tbl%0d grant", i), 32'(grant),       32'(vecs[i].eg));
            checkOutput($sformatf("tbl%0d r0", i),    32'(m0_ready),    32'(vecs[i].er0));
            checkOutput($sformatf("tbl%0d r1", i),    32'(m1_ready),    32'(vecs[i].er1));
            checkOutput($sformatf("tbl%0d err", i),   32'(err_timeout), 32'(vecs[i].eerr));
            checkOutput($sformatf("tbl%0d rd0", i),   m0_rdata,         vecs[i].erd0);
            checkOutput($sformatf("tbl%0d rd1", i),   m1_rdata,         vecs[i].erd1);
        end

        // Both masters held busy: completions must alternate m0,m1,m0,...
        doReset();
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
            if (m0_ready || m1_ready) begin
                checkOutput($sformatf("alt%0d both", n), 32'(m0_ready && m1_ready), 32'h0);
                checkOutput($sformatf("alt%0d owner", n), 32'(m1_ready), 32'(n % 2));
                n++;
            end
        end
        checkOutput("alt count", 32'(n), 32'd8);

        // Watchdog: m1 reads with no slave response.
        m1_addr = 32'h9000_0000;
        found = 0;
        for (int c = 0; c < 6 && found == 0; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            if (grant == 2'b10) found = 1;
        end
        checkOutput("to grant seen", 32'(found), 32'd1);
        for (int k = 1; k <= TO; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            if (k < TO) begin
                checkOutput($sformatf("to k%0d err", k), 32'(err_timeout), 32'h0);
                checkOutput($sformatf("to k%0d rdy", k), 32'(m1_ready),    32'h0);
            end else begin
                checkOutput("to err",     32'(err_timeout), 32'h1);
                checkOutput("to rdy",     32'(m1_ready),    32'h1);
                checkOutput("to rdata",   m1_rdata,         TRD);
                checkOutput("to s_valid", 32'(s_valid),     32'h0);
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("post-to idle", 32'(grant), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hCAFE_0001, 1'b0);
        checkOutput("post-to m0 grant", 32'(grant),    32'h1);
        checkOutput("post-to m0 ready", 32'(m0_ready), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Reset dropped in the middle of an m1 transaction.
        found = 0;
        for (int c = 0; c < 6 && found == 0; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            if (grant == 2'b10) found = 1;
        end
        checkOutput("rst mid grant seen", 32'(found), 32'd1);
        #2;
        s_ready = 1'b1;
        resetn  = 1'b0;
        modelReset();
        #1;
        checkOutput("rst mid grant",    32'(grant),    32'h0);
        checkOutput("rst mid s_valid",  32'(s_valid),  32'h0);
        checkOutput("rst mid m1_ready", 32'(m1_ready), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn   = 1'b1;
        m0_valid = 1'b1;
        m1_valid = 1'b1;
        s_ready  = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h7777_0000, 1'b0);
        checkOutput("rst tie grant",    32'(grant),    32'h1);
        checkOutput("rst tie m0_ready", 32'(m0_ready), 32'h1);
        checkOutput("rst tie m1_ready", 32'(m1_ready), 32'h0);

        // Randomized traffic against the model.
        checkModel(-1);
        for (int c = 0; c < 400; c++) begin
            v0 = m0_valid;
            v1 = m1_valid;
            if (!v0 || exp_r0)                 v0 = 1'($urandom_range(0, 1));
            else if ($urandom_range(0, 39) == 0) v0 = 1'b0;
            if (!v1 || exp_r1)                 v1 = 1'($urandom_range(0, 1));
            else if ($urandom_range(0, 39) == 0) v1 = 1'b0;
            applyStimulus(v0, v1, ($urandom_range(0, 4) == 0), $urandom(), 1'b1);
            checkModel(c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter2.md
BUS_ARBITER2 -- requirements
Module: bus_arbiter2

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: slave-response watchdog limit in cycles; 0 disables the watchdog.
REQ-002 SHALL have parameter [31:0] TIMEOUT_RDATA, default 32'h0000_0000: read data returned to a master on timeout.
REQ-003 SHALL have port clk  input  1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have ports m0_valid, m1_valid  input  1 each: master request (m0 = CPU, m1 = secondary master/DMA).
REQ-006 SHALL have ports m0_addr, m1_addr  input  32 each: request address.
REQ-007 SHALL have ports m0_wdata, m1_wdata  input  32 each: write data.
REQ-008 SHALL have ports m0_wstrb, m1_wstrb  input  4 each: byte write strobes; 0 = read.
REQ-009 SHALL have ports m0_ready, m1_ready  output  1 each: transfer-complete pulse to the master.
REQ-010 SHALL have ports m0_rdata, m1_rdata  output  32 each: read data to the master.
REQ-011 SHALL have port s_valid  output  1: request to the shared slave bus.
REQ-012 SHALL have ports s_addr  output  32, s_wdata  output  32, s_wstrb  output  4: the granted master's request fields.
REQ-013 SHALL have ports s_ready  input  1 and s_rdata  input  32: slave response.
REQ-014 SHALL have port grant  output  2: one-hot current owner ({m1,m0}); 2'b00 when idle.
REQ-015 SHALL have port err_timeout  output  1: one-cycle pulse when the watchdog fires.

Function
REQ-016 SHALL implement FSM states IDLE, GNT0, GNT1.
REQ-017 In IDLE, with exactly one valid request, the FSM SHALL move to that master's GNTx on the next edge.
REQ-018 In IDLE, with both masters valid, the FSM SHALL grant the master not recorded in last_grant (round-robin).
REQ-019 In GNTx, s_valid/s_addr/s_wdata/s_wstrb SHALL equal mx_* combinationally. In IDLE, s_valid SHALL be 0 and the other s_* fields SHALL be 0.
REQ-020 In GNTx, mx_ready SHALL equal s_ready, combinationally, and mx_rdata SHALL equal s_rdata. A master that is not granted SHALL see ready = 0 and rdata = 0.
REQ-021 When mx_ready is asserted in GNTx, the FSM SHALL return to IDLE on the next edge and last_grant SHALL be set to x.
- Minimum spacing of grants is one IDLE turnaround cycle.
REQ-022 s_ready arriving while in IDLE SHALL be ignored; this covers the trailing pulse from a slave with registered ready.
REQ-023 The watchdog counter SHALL clear on entry to GNTx and increment each GNTx cycle without s_ready.
REQ-024 When TIMEOUT != 0 and the watchdog count equals TIMEOUT, the arbiter SHALL do all of the following in that cycle:
- assert mx_ready for one cycle;
- drive mx_rdata = TIMEOUT_RDATA;
- keep s_valid deasserted;
- pulse err_timeout;
- return to IDLE.
REQ-025 The counter SHALL saturate rather than wrap.
REQ-026 If mx_valid drops while in GNTx (protocol violation), the FSM SHALL return to IDLE on the next edge without asserting ready, and last_grant SHALL be updated to x.
REQ-027 A request arriving while the other master holds the grant SHALL wait. No request SHALL be lost or reordered.
REQ-028 Worst-case wait SHALL be one full transaction of the other master plus one turnaround cycle.
REQ-029 s_ready and timeout in the same cycle SHALL be treated as normal completion: s_rdata is returned and err_timeout stays 0.

Reset
REQ-030 While resetn = 0, asynchronously and regardless of clk:
- FSM = IDLE;
- last_grant = m1, so m0 wins the first tie;
- watchdog = 0;
- grant = 0, err_timeout = 0, all mx_ready = 0, s_valid = 0.
REQ-031 Reset asserted mid-transaction SHALL abort that transaction; no ready SHALL be issued for it after release.

Structure
REQ-032 State encodings (IDLE/GNT0/GNT1), the master-count constant and the default TIMEOUT SHALL live in the shared package bus_arb_pkg.
REQ-033 The watchdog SHALL be a sub-module bus_watchdog, with inputs clk, resetn, clear, run, limit and output expired.
REQ-034 Request/response muxing SHALL be combinational in bus_arbiter2; only FSM, last_grant and watchdog are registered.

Verification
REQ-035 Scenario: m0 only, read 0x0000_0010, slave ready after 1 cycle with rdata 0x1234_5678 -> grant=01 one cycle after valid; m0_ready one pulse; m0_rdata=0x1234_5678; m1_ready stays 0.
REQ-036 Scenario: m0 and m1 valid in the same cycle after reset -> m0 served first. Then an IDLE cycle, then m1 (grant 01,00,10).
REQ-037 Scenario: m0 and m1 both held valid continuously for 4 transactions each -> strict alternation m0,m1,m0,m1...
REQ-038 Scenario: TIMEOUT=8, m1 reads 0x9000_0000, s_ready never asserted -> m1_ready and err_timeout pulse 8 cycles after the grant; m1_rdata=TIMEOUT_RDATA; bus then free for m0.
REQ-039 Scenario: slave whose ready lags one cycle (registered) -> the trailing s_ready in IDLE produces no ready to either master.
REQ-040 Scenario: resetn dropped mid-GNT1 -> grant, s_valid and m1_ready go to 0 immediately. After release, m0 wins the first tie.
